// File: rtl/add_share_arbiter_pkg.sv
// Shared state encoding and default widths for the two-requester adder sharing block.
package add_share_arbiter_pkg;

  localparam int DEF_W     = 8;
  localparam int DEF_CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/add_share_arbiter_adder.sv
// Plain unsigned W-bit adder with carry-out; purely combinational, no flow control.
module NBitAdder #(
  parameter int W = 8
) (
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  output logic [W:0]   C
);

  assign C = {1'b0, A} + {1'b0, B};

endmodule

// File: rtl/add_share_arbiter.sv
// Round-robin share of one adder between two requesters; accept edge t -> rsp_valid from t+2.
// Response is held under rsp_ready backpressure; no request is accepted until the response is taken.
module add_share_arbiter
  import add_share_arbiter_pkg::*;
#(
  parameter int W     = DEF_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic [W-1:0]     req0_a,
  input  logic [W-1:0]     req0_b,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [W-1:0]     req1_a,
  input  logic [W-1:0]     req1_b,
  output logic             req1_ready,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [W:0]       rsp_sum,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  state_t       state;
  logic         last_grant;
  logic [W-1:0] op_a_q;
  logic [W-1:0] op_b_q;
  logic [W:0]   sum_w;
  logic         grant0;
  logic         grant1;

  // On contention the requester that did not win last time gets the adder.
  assign grant0     = (state == IDLE) && req0_valid && (!req1_valid || last_grant);
  assign grant1     = (state == IDLE) && req1_valid && (!req0_valid || !last_grant);
  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign busy       = (state != IDLE);

  NBitAdder #(.W(W)) u_adder (
    .A(op_a_q),
    .B(op_b_q),
    .C(sum_w)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      op_a_q     <= '0;
      op_b_q     <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_sum    <= '0;
      op_count   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (grant0) begin
            op_a_q     <= req0_a;
            op_b_q     <= req0_b;
            rsp_id     <= 1'b0;
            last_grant <= 1'b0;
            state      <= ADD;
          end else if (grant1) begin
            op_a_q     <= req1_a;
            op_b_q     <= req1_b;
            rsp_id     <= 1'b1;
            last_grant <= 1'b1;
            state      <= ADD;
          end
        end
        ADD: begin
          rsp_sum   <= sum_w;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            op_count  <= op_count + 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_add_share_arbiter.sv
// Bench for add_share_arbiter: table vectors, hand sequences and random traffic against a transaction model.
module tb_add_share_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0_valid, req1_valid, rsp_ready;
  logic [7:0] req0_a, req0_b, req1_a, req1_b;
  logic       req0_ready, req1_ready, rsp_valid, rsp_id, busy;
  logic [8:0] rsp_sum;
  logic [15:0] op_count;
  // Narrow-counter copy sees identical stimulus; only its counter width differs.
  logic       w_req0_ready, w_req1_ready, w_rsp_valid, w_rsp_id, w_busy;
  logic [8:0] w_rsp_sum;
  logic [1:0] w_op_count;

  add_share_arbiter #(.W(8), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_sum(rsp_sum),
    .busy(busy), .op_count(op_count)
  );

  add_share_arbiter #(.W(8), .CNT_W(2)) u_wrap (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(w_req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(w_req1_ready),
    .rsp_valid(w_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(w_rsp_id), .rsp_sum(w_rsp_sum),
    .busy(w_busy), .op_count(w_op_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Transaction-level model: who owns the adder, how many cycles it has held it, what it owes.
  bit owned;
  int age;
  int m_last;
  int m_id;
  int m_sum;
  int m_ops;
  bit acc0, acc1, done;
  int got_id, got_sum;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    owned = 0; age = 0; m_last = 1; m_id = 0; m_sum = 0; m_ops = 0;
  endtask

  function automatic int winner();
    if (owned) return -1;
    if (req0_valid && req1_valid) return 1 - m_last;
    if (req0_valid) return 0;
    if (req1_valid) return 1;
    return -1;
  endfunction

  task automatic check_now();
    int w;
    w = winner();
    chk("req0_ready", int'(req0_ready), int'(w == 0));
    chk("req1_ready", int'(req1_ready), int'(w == 1));
    chk("busy", int'(busy), int'(owned));
    chk("rsp_valid", int'(rsp_valid), int'(owned && age >= 1));
    if (owned && age >= 1) begin
      chk("rsp_id", int'(rsp_id), m_id);
      chk("rsp_sum", int'(rsp_sum), m_sum);
    end
    chk("op_count", int'(op_count), m_ops % 65536);
    chk("op_count_wrap", int'(w_op_count), m_ops % 4);
  endtask

  // One clock: check settled outputs, advance the model across the edge.
  task automatic tick();
    int w;
    #2;
    check_now();
    acc0 = 0; acc1 = 0; done = 0;
    w = winner();
    if (owned) begin
      if (age >= 1 && rsp_ready) begin
        got_id = int'(rsp_id); got_sum = int'(rsp_sum);
        owned = 0; m_ops++; done = 1;
      end else age++;
    end else if (w >= 0) begin
      owned = 1; age = 0; m_id = w; m_last = w;
      m_sum = (w == 0) ? int'(req0_a) + int'(req0_b) : int'(req1_a) + int'(req1_b);
      acc0 = (w == 0); acc1 = (w == 1);
    end
    @(posedge clk); #1;
    if (acc0) req0_valid = 0;
    if (acc1) req1_valid = 0;
  endtask

  task automatic run_to_done(input string name);
    int n;
    n = 0;
    done = 0;
    while (!done && n < 30) begin tick(); n++; end
    if (!done) begin
      total++; bad++;
      $display("FAIL %s: no response handshake within 30 cycles", name);
    end
  endtask

  typedef struct {
    bit v0; logic [7:0] a0, b0;
    bit v1; logic [7:0] a1, b1;
    int exp_id; int exp_sum;
  } vec_t;

  vec_t vt[7];

  initial begin
    int seq[5];
    logic [8:0] held;
    vt[0] = '{1, 8'h0F, 8'h01, 0, 8'h00, 8'h00, 0, 'h010};
    vt[1] = '{0, 8'h00, 8'h00, 1, 8'hFF, 8'hFF, 1, 'h1FE};
    vt[2] = '{1, 8'd3,  8'd4,  1, 8'd10, 8'd20, 0, 7};
    vt[3] = '{1, 8'd3,  8'd4,  1, 8'd10, 8'd20, 1, 30};
    vt[4] = '{1, 8'd3,  8'd4,  1, 8'd10, 8'd20, 0, 7};
    vt[5] = '{1, 8'd3,  8'd4,  1, 8'd10, 8'd20, 1, 30};
    vt[6] = '{1, 8'd3,  8'd4,  0, 8'd0,  8'd0,  0, 7};
    seq = '{1, 2, 3, 0, 1};

    rst_n = 0; rsp_ready = 0;
    req0_valid = 0; req1_valid = 0;
    req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0;
    model_reset();
    #12;
    chk("reset_rsp_valid", int'(rsp_valid), 0);
    chk("reset_rsp_id", int'(rsp_id), 0);
    chk("reset_rsp_sum", int'(rsp_sum), 0);
    chk("reset_op_count", int'(op_count), 0);
    chk("reset_busy", int'(busy), 0);
    #11 rst_n = 1;
    @(posedge clk); #1;

    // Single, carry-out and alternating contention vectors.
    rsp_ready = 1;
    for (int i = 0; i < 7; i++) begin
      req0_valid = vt[i].v0; req0_a = vt[i].a0; req0_b = vt[i].b0;
      req1_valid = vt[i].v1; req1_a = vt[i].a1; req1_b = vt[i].b1;
      run_to_done($sformatf("vec%0d", i));
      chk($sformatf("vec%0d_id", i), got_id, vt[i].exp_id);
      chk($sformatf("vec%0d_sum", i), got_sum, vt[i].exp_sum);
    end
    chk("ops_after_table", int'(op_count), 7);

    // Backpressure: hold response 5 cycles with a competing request pending.
    rsp_ready = 0;
    req0_valid = 1; req0_a = 8'd5; req0_b = 8'd6;
    tick(); tick();
    held = rsp_sum;
    req1_valid = 1; req1_a = 8'd1; req1_b = 8'd2;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_sum_stable", int'(rsp_sum), int'(held));
      chk("bp_valid_held", int'(rsp_valid), 1);
    end
    rsp_ready = 1;
    tick();
    chk("bp_back_idle", int'(busy), 0);
    chk("bp_count", int'(op_count), 8);
    run_to_done("bp_followup");
    chk("bp_followup_sum", got_sum, 3);

    // Reset while the adder is busy.
    req0_valid = 1; req0_a = 8'd4; req0_b = 8'd4;
    tick();
    req0_valid = 0;
    #2 rst_n = 0;
    #1;
    chk("rst_rsp_valid", int'(rsp_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_op_count", int'(op_count), 0);
    chk("rst_wrap_count", int'(w_op_count), 0);
    model_reset();
    #2 rst_n = 1;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) tick();
    req0_valid = 1; req0_a = 8'd1; req0_b = 8'd1;
    req1_valid = 1; req1_a = 8'd2; req1_b = 8'd2;
    #1;
    chk("rst_first_grant0", int'(req0_ready), 1);
    run_to_done("rst_first");
    chk("rst_first_id", got_id, 0);
    run_to_done("rst_second");
    chk("rst_second_id", got_id, 1);

    // Narrow counter wraps after four operations.
    model_reset();
    rst_n = 0; #1 rst_n = 1;
    @(posedge clk); #1;
    for (int k = 0; k < 5; k++) begin
      req1_valid = 1; req1_a = 8'(k); req1_b = 8'd9;
      run_to_done("wrap_op");
      #2;
      chk($sformatf("wrap_count%0d", k), int'(w_op_count), seq[k]);
      @(posedge clk); #1;
      tick();
    end

    // Random traffic.
    for (int c = 0; c < 600; c++) begin
      if (!req0_valid && ($urandom % 2 == 1)) begin
        req0_valid = 1; req0_a = 8'($urandom); req0_b = 8'($urandom);
      end
      if (!req1_valid && ($urandom % 2 == 1)) begin
        req1_valid = 1; req1_a = 8'($urandom); req1_b = 8'($urandom);
      end
      rsp_ready = ($urandom % 3 != 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Model-free safety net against a stuck simulation.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/add_share_arbiter.md
Name: add_share_arbiter

Overview:
Round-robin arbiter and sequencer that time-shares a single NBitAdder datapath instance between two requesters.
Each requester presents an operand pair through a valid/ready handshake. The block grants one request, latches its operands and drives them through the adder. It then returns the registered (W+1)-bit sum on a shared response channel, tagged with the requester ID, and holds it under backpressure.
The block sits between client logic and the existing adder, so that only one adder is needed in the design.

Parameters:
W, 8, operand width in bits; sum width is W+1.
CNT_W, 16, width of the completed-operation counter.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
req0_valid  in  1  requester 0 has an operand pair
req0_a  in  W  requester 0 operand A
req0_b  in  W  requester 0 operand B
req0_ready  out  1  requester 0 request accepted this cycle
req1_valid  in  1  requester 1 has an operand pair
req1_a  in  W  requester 1 operand A
req1_b  in  W  requester 1 operand B
req1_ready  out  1  requester 1 request accepted this cycle
rsp_valid  out  1  response holds a valid sum
rsp_ready  in  1  consumer accepts the response
rsp_id  out  1  requester that owns the response
rsp_sum  out  W+1  A+B, including carry-out
busy  out  1  high whenever state is not IDLE
op_count  out  CNT_W  number of completed response handshakes; wraps

Behaviour:
- Clock and reset: one clock domain, clk. rst_n is asynchronous and active-low.
- Reset values: state=IDLE, rsp_valid=0, rsp_id=0, rsp_sum=0, op_count=0, last_grant=1 (so requester 0 wins the first contention), operand registers=0.
- req*_ready and busy are combinational from state and the valid inputs.
- Requesters must hold valid and operands stable until their ready is seen high. Valid must not depend on ready.
- FSM states: IDLE, ADD, RESP.
- IDLE:
  - Only one valid: grant it.
  - Both valid: grant the requester not equal to last_grant.
  - Granted requester: reqN_ready=1 in that same cycle. Next edge latches its operands and ID, updates last_grant, and moves to ADD.
  - No valid: stay in IDLE; both readys are 0.
- ADD: latched operands drive the NBitAdder instance. Next edge registers the adder's (W+1)-bit output into rsp_sum, sets rsp_valid=1, and moves to RESP.
- RESP:
  - rsp_valid=1. rsp_sum and rsp_id are held stable until rsp_ready=1.
  - On rsp_valid&&rsp_ready: op_count increments, rsp_valid clears and state returns to IDLE.
  - op_count wraps from all-ones to 0.
- Latency: accept edge at cycle t gives rsp_valid high from cycle t+2. Peak throughput is one operation per 3 cycles.
- Ready is never asserted in ADD or RESP. New requests wait; no queueing.
- Arithmetic: unsigned; sum is exactly A+B in W+1 bits; there is no overflow loss.
- Reset mid-operation (any state): the in-flight operation is dropped with no response. All outputs return to their reset values immediately.
- Simultaneous events:
  - rsp_ready asserted while not in RESP is ignored.
  - A requester dropping valid at the same edge its ready is high is still accepted.

Decomposition:
- Shared header/package: state encodings (IDLE=2'd0, ADD=2'd1, RESP=2'd2) and default width constants.
- Sub-module: one instance of the existing NBitAdder with parameter W, connected as A=op_a_q, B=op_b_q, C=sum_w.
- The FSM, arbiter and counter stay in add_share_arbiter.

Test Plan:
1. Single request (W=8): req0 only, a=8'h0F, b=8'h01, rsp_ready=1. Required: req0_ready high one cycle; rsp_valid 2 cycles after accept; rsp_id=0, rsp_sum=9'h010; op_count=1.
2. Carry-out: req1 only, a=8'hFF, b=8'hFF. Required: rsp_id=1, rsp_sum=9'h1FE.
3. Contention and round-robin: both valid continuously, req0 (3+4), req1 (10+20). Required: grants alternate 0,1,0,1 starting with 0; sums 7, 30, 7, 30.
4. Backpressure: rsp_ready=0 for 5 cycles in RESP. Required:
   - rsp_valid and rsp_sum stay stable;
   - both readys stay 0;
   - one cycle after rsp_ready=1, state returns to IDLE and op_count increments once.
5. Reset mid-op: assert rst_n=0 asynchronously while in ADD. Required: rsp_valid=0, busy=0 and op_count=0 immediately; no response after release; the first grant after release goes to req0.
6. Counter wrap: CNT_W=2, run 5 operations. Required: op_count sequence 1, 2, 3, 0, 1.
